// File: rtl/jtkunio_dwnld_pkg.sv
// Shared definitions for the Kunio ROM download router: ROM image layout,
// region codes, FSM encoding and the buffered entry format.
package jtkunio_dwnld_pkg;

  // ioctl byte offsets of each ROM section; the MRA generator uses the same values
  localparam logic [24:0] DEF_SND_START  = 25'h10000;
  localparam logic [24:0] DEF_PCM_START  = 25'h18000;
  localparam logic [24:0] DEF_CHAR_START = 25'h38000;
  localparam logic [24:0] DEF_SCR_START  = 25'h40000;
  localparam logic [24:0] DEF_OBJ_START  = 25'h60000;
  localparam logic [24:0] DEF_MCU_START  = 25'hA0000;
  localparam logic [24:0] DEF_ROM_END    = 25'hA0800;

  typedef enum logic [2:0] {
    BA0  = 3'd0,
    BA1  = 3'd1,
    BA2  = 3'd2,
    BA3  = 3'd3,
    MCU  = 3'd4,
    NONE = 3'd5
  } region_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SDWR = 2'd1,
    PROM = 2'd2,
    GAP  = 2'd3
  } state_e;

  typedef struct packed {
    region_e     region;
    logic [1:0]  ba;
    logic [21:0] word;
    logic [1:0]  mask;
    logic [7:0]  data;
  } entry_t;

endpackage

// File: rtl/jtkunio_dwnld_if.sv
// Download-side bus: ioctl byte stream in, SDRAM programming port and
// MCU PROM strobe out, plus status flags.
interface jtkunio_dwnld_if;
  logic        downloading;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wr;
  logic [21:0] prog_addr;
  logic [15:0] prog_data;
  logic [1:0]  prog_mask;
  logic [1:0]  prog_ba;
  logic        prog_we;
  logic        prog_ack;
  logic        prom_we;
  logic        dwnld_busy;
  logic        ovf;

  modport master (
    output downloading, ioctl_addr, ioctl_dout, ioctl_wr, prog_ack,
    input  prog_addr, prog_data, prog_mask, prog_ba, prog_we, prom_we,
           dwnld_busy, ovf
  );

  modport slave (
    input  downloading, ioctl_addr, ioctl_dout, ioctl_wr, prog_ack,
    output prog_addr, prog_data, prog_mask, prog_ba, prog_we, prom_we,
           dwnld_busy, ovf
  );
endinterface

// File: rtl/jtkunio_dwnld_dec.sv
// Combinational ROM region decoder: ioctl byte address to region, SDRAM
// bank, word address (or PROM address for the MCU) and byte-lane mask.
module jtkunio_dwnld_dec
  import jtkunio_dwnld_pkg::*;
#(
  parameter logic [24:0] SND_START  = DEF_SND_START,
  parameter logic [24:0] PCM_START  = DEF_PCM_START,
  parameter logic [24:0] CHAR_START = DEF_CHAR_START,
  parameter logic [24:0] OBJ_START  = DEF_OBJ_START,
  parameter logic [24:0] MCU_START  = DEF_MCU_START,
  parameter logic [24:0] ROM_END    = DEF_ROM_END
) (
  input  logic [24:0] addr_i,
  output region_e     region_o,
  output logic [1:0]  ba_o,
  output logic [21:0] word_o,
  output logic [1:0]  mask_o
);

  // Byte offset inside the region; no region is larger than 23 bits
  logic [22:0] off;

  always_comb begin
    region_o = NONE;
    ba_o     = 2'd0;
    off      = 23'd0;
    word_o   = 22'd0;
    // main and sound ROMs sit back to back in bank 0
    if (addr_i < SND_START) begin
      region_o = BA0;
      off      = addr_i[22:0];
    end else if (addr_i < PCM_START) begin
      region_o = BA0;
      off      = addr_i[22:0];
    end else if (addr_i < CHAR_START) begin
      region_o = BA1;
      ba_o     = 2'd1;
      off      = 23'(addr_i - PCM_START);
    end else if (addr_i < OBJ_START) begin
      region_o = BA2;
      ba_o     = 2'd2;
      off      = 23'(addr_i - CHAR_START);
    end else if (addr_i < MCU_START) begin
      region_o = BA3;
      ba_o     = 2'd3;
      off      = 23'(addr_i - OBJ_START);
    end else if (addr_i < ROM_END) begin
      region_o = MCU;
      off      = 23'(addr_i - MCU_START);
    end

    if (region_o == MCU) begin
      word_o = {11'd0, off[10:0]};
    end else if (region_o != NONE) begin
      word_o = off[22:1];
    end
  end

  // A mask bit set means that byte lane is left untouched
  assign mask_o = addr_i[0] ? 2'b01 : 2'b10;

endmodule

// File: rtl/jtkunio_dwnld.sv
// Kunio download router: buffers one ioctl byte, issues it as an SDRAM
// write held until acknowledged, or as a one-cycle MCU PROM strobe.
module jtkunio_dwnld
  import jtkunio_dwnld_pkg::*;
#(
  parameter logic [24:0] SND_START  = DEF_SND_START,
  parameter logic [24:0] PCM_START  = DEF_PCM_START,
  parameter logic [24:0] CHAR_START = DEF_CHAR_START,
  parameter logic [24:0] OBJ_START  = DEF_OBJ_START,
  parameter logic [24:0] MCU_START  = DEF_MCU_START,
  parameter logic [24:0] ROM_END    = DEF_ROM_END
) (
  input  logic           clk,
  input  logic           rst,
  jtkunio_dwnld_if.slave dl
);

  region_e     dec_region;
  logic [1:0]  dec_ba;
  logic [21:0] dec_word;
  logic [1:0]  dec_mask;

  jtkunio_dwnld_dec #(
    .SND_START  (SND_START),
    .PCM_START  (PCM_START),
    .CHAR_START (CHAR_START),
    .OBJ_START  (OBJ_START),
    .MCU_START  (MCU_START),
    .ROM_END    (ROM_END)
  ) u_dec (
    .addr_i   (dl.ioctl_addr),
    .region_o (dec_region),
    .ba_o     (dec_ba),
    .word_o   (dec_word),
    .mask_o   (dec_mask)
  );

  state_e      state_q, state_d;
  entry_t      buf_q, buf_d;
  logic        buf_valid_q, buf_valid_d;
  logic        ovf_q, ovf_d;
  logic [21:0] prog_addr_q, prog_addr_d;
  logic [15:0] prog_data_q, prog_data_d;
  logic [1:0]  prog_mask_q, prog_mask_d;
  logic [1:0]  prog_ba_q, prog_ba_d;
  logic        prog_we_q, prog_we_d;
  logic        prom_we_q, prom_we_d;
  logic        release_buf;
  logic        accept;
  logic [15:0] lane_data;

  // The buffered byte is replicated on both lanes; the mask selects one
  for (genvar gi = 0; gi < 2; gi++) begin : g_lane
    assign lane_data[gi*8 +: 8] = buf_q.data;
  end

  always_comb begin
    state_d     = state_q;
    prog_addr_d = prog_addr_q;
    prog_data_d = prog_data_q;
    prog_mask_d = prog_mask_q;
    prog_ba_d   = prog_ba_q;
    prog_we_d   = prog_we_q;
    prom_we_d   = 1'b0;
    release_buf = 1'b0;
    case (state_q)
      IDLE: begin
        if (buf_valid_q) begin
          release_buf = 1'b1;
          prog_addr_d = buf_q.word;
          prog_data_d = lane_data;
          if (buf_q.region == MCU) begin
            state_d   = PROM;
            prom_we_d = 1'b1;
          end else begin
            state_d     = SDWR;
            prog_we_d   = 1'b1;
            prog_ba_d   = buf_q.ba;
            prog_mask_d = buf_q.mask;
          end
        end
      end
      SDWR: begin
        if (dl.prog_ack) begin
          state_d   = GAP;
          prog_we_d = 1'b0;
        end
      end
      PROM:    state_d = GAP;
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A slot freed by an issue this cycle can take the incoming byte
  always_comb begin
    accept      = dl.downloading & dl.ioctl_wr & (dec_region != NONE);
    buf_valid_d = buf_valid_q & ~release_buf;
    buf_d       = buf_q;
    ovf_d       = ovf_q;
    if (accept) begin
      if (buf_valid_d) begin
        ovf_d = 1'b1;
      end else begin
        buf_valid_d = 1'b1;
        buf_d       = '{region: dec_region, ba: dec_ba, word: dec_word,
                        mask: dec_mask, data: dl.ioctl_dout};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      buf_q       <= '0;
      buf_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      prog_addr_q <= 22'd0;
      prog_data_q <= 16'd0;
      prog_mask_q <= 2'd0;
      prog_ba_q   <= 2'd0;
      prog_we_q   <= 1'b0;
      prom_we_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      buf_valid_q <= buf_valid_d;
      ovf_q       <= ovf_d;
      prog_addr_q <= prog_addr_d;
      prog_data_q <= prog_data_d;
      prog_mask_q <= prog_mask_d;
      prog_ba_q   <= prog_ba_d;
      prog_we_q   <= prog_we_d;
      prom_we_q   <= prom_we_d;
    end
  end

  assign dl.prog_addr  = prog_addr_q;
  assign dl.prog_data  = prog_data_q;
  assign dl.prog_mask  = prog_mask_q;
  assign dl.prog_ba    = prog_ba_q;
  assign dl.prog_we    = prog_we_q;
  assign dl.prom_we    = prom_we_q;
  assign dl.ovf        = ovf_q;
  assign dl.dwnld_busy = dl.downloading | buf_valid_q | (state_q != IDLE);

endmodule

// File: tb/tb_jtkunio_dwnld.sv
// Bench for jtkunio_dwnld: directed scenarios plus random byte streams,
// checked cycle by cycle against a timestamp-based transaction model.
module tb_jtkunio_dwnld;
  import jtkunio_dwnld_pkg::*;

  localparam int SND = int'(DEF_SND_START);
  localparam int PCM = int'(DEF_PCM_START);
  localparam int CHR = int'(DEF_CHAR_START);
  localparam int SCR = int'(DEF_SCR_START);
  localparam int OBJ = int'(DEF_OBJ_START);
  localparam int MCUA = int'(DEF_MCU_START);
  localparam int ENDA = int'(DEF_ROM_END);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  jtkunio_dwnld_if dl();
  jtkunio_dwnld dut (.clk(clk), .rst(rst), .dl(dl));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  typedef struct packed {
    bit        sd;
    bit [1:0]  ba;
    bit [21:0] word;
    bit [1:0]  mask;
    bit [7:0]  data;
  } item_t;

  // Model: one buffer slot, an outstanding-SDRAM flag and the cycle at which
  // the router can next issue.
  bit    m_buf_v;
  item_t m_buf, m_last;
  bit    m_wait;
  int    m_idle_at;
  int    m_prom_at;
  bit    m_ovf;
  int    cyc;

  function automatic bit classify(input int a, output item_t it);
    it      = '0;
    it.mask = (a % 2 == 1) ? 2'b01 : 2'b10;
    if (a < PCM) begin
      it.sd = 1'b1; it.ba = 2'd0; it.word = 22'(a / 2);
    end else if (a < CHR) begin
      it.sd = 1'b1; it.ba = 2'd1; it.word = 22'((a - PCM) / 2);
    end else if (a < OBJ) begin
      it.sd = 1'b1; it.ba = 2'd2; it.word = 22'((a - CHR) / 2);
    end else if (a < MCUA) begin
      it.sd = 1'b1; it.ba = 2'd3; it.word = 22'((a - OBJ) / 2);
    end else if (a < ENDA) begin
      it.sd = 1'b0; it.word = 22'(a - MCUA);
    end else begin
      return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_buf_v   = 1'b0;
    m_wait    = 1'b0;
    m_idle_at = 0;
    m_prom_at = -1;
    m_ovf     = 1'b0;
  endtask

  // One clock cycle: drive, compare against the model, advance the model.
  task automatic step(input bit dl_in, input bit wr, input int addr,
                      input bit [7:0] d, input bit ack);
    item_t it;
    bit    idle;
    dl.downloading = dl_in;
    dl.ioctl_wr    = wr;
    dl.ioctl_addr  = 25'(addr);
    dl.ioctl_dout  = d;
    dl.prog_ack    = ack;
    @(negedge clk);
    idle = !m_wait && (cyc >= m_idle_at);
    check("prog_we", dl.prog_we, m_wait);
    check("prom_we", dl.prom_we, cyc == m_prom_at);
    check("busy", dl.dwnld_busy, dl_in | m_buf_v | !idle);
    check("ovf", dl.ovf, m_ovf);
    if (m_wait) begin
      check("prog_ba", dl.prog_ba, m_last.ba);
      check("prog_mask", dl.prog_mask, m_last.mask);
      check("prog_addr", dl.prog_addr, m_last.word);
      check("prog_data", dl.prog_data, {m_last.data, m_last.data});
    end
    if (cyc == m_prom_at) begin
      check("prom_addr", dl.prog_addr[10:0], m_last.word[10:0]);
      check("prom_data", dl.prog_data[7:0], m_last.data);
    end
    if (idle && m_buf_v) begin
      m_last  = m_buf;
      m_buf_v = 1'b0;
      if (m_buf.sd) begin
        m_wait = 1'b1;
        $display("cyc %0d sdram ba=%0d word=%06h mask=%b data=%02h",
                 cyc + 1, m_buf.ba, m_buf.word, m_buf.mask, m_buf.data);
      end else begin
        m_prom_at = cyc + 1;
        m_idle_at = cyc + 3;
        $display("cyc %0d prom  addr=%03h data=%02h", cyc + 1, m_buf.word[10:0], m_buf.data);
      end
    end else if (m_wait && ack) begin
      m_wait    = 1'b0;
      m_idle_at = cyc + 2;
    end
    if (dl_in && wr && classify(addr, it)) begin
      if (m_buf_v) begin
        m_ovf = 1'b1;
      end else begin
        it.data = d;
        m_buf   = it;
        m_buf_v = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic sd_write(input int addr, input bit [7:0] d, input int exp_ba,
                          input int exp_word, input int delay);
    step(1, 1, addr, d, 0);
    step(1, 0, 0, 0, 0);
    check("bnd_we", dl.prog_we, 1);
    check("bnd_ba", dl.prog_ba, 32'(exp_ba));
    check("bnd_word", dl.prog_addr, 32'(exp_word));
    repeat (delay) step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int edges [7];

  initial begin
    edges = '{SND, PCM, CHR, SCR, OBJ, MCUA, ENDA};
    rst            = 1'b1;
    dl.downloading = 1'b0;
    dl.ioctl_wr    = 1'b0;
    dl.ioctl_addr  = '0;
    dl.ioctl_dout  = '0;
    dl.prog_ack    = 1'b0;
    cyc            = 0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_prog_we", dl.prog_we, 0);
    check("rst_prom_we", dl.prom_we, 0);
    check("rst_busy", dl.dwnld_busy, 0);
    check("rst_ovf", dl.ovf, 0);
    check("rst_addr", dl.prog_addr, 0);
    check("rst_data", dl.prog_data, 0);
    check("rst_mask", dl.prog_mask, 0);
    check("rst_ba", dl.prog_ba, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Bank 0 write, held until ack
    step(1, 1, 'h3, 8'hA5, 0);
    step(1, 0, 0, 0, 0);
    check("b0_we", dl.prog_we, 1);
    check("b0_ba", dl.prog_ba, 0);
    check("b0_addr", dl.prog_addr, 22'h1);
    check("b0_mask", dl.prog_mask, 2'b01);
    check("b0_data", dl.prog_data, 16'hA5A5);
    repeat (3) step(1, 0, 0, 0, 0);
    check("b0_hold", dl.prog_we, 1);
    step(1, 0, 0, 0, 1);
    check("b0_release", dl.prog_we, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);

    // Region boundaries
    sd_write('h17FFF, 8'h11, 0, 'hBFFF, 1);
    sd_write('h18000, 8'h22, 1, 0, 0);
    sd_write('h5FFFF, 8'h33, 2, 'h13FFF, 2);
    sd_write('h60000, 8'h44, 3, 0, 0);

    // MCU PROM strobe, then an out-of-image byte
    step(1, 1, 'hA0005, 8'h3C, 0);
    step(1, 0, 0, 0, 0);
    check("mcu_strobe", dl.prom_we, 1);
    check("mcu_addr", dl.prog_addr[10:0], 11'h005);
    check("mcu_data", dl.prog_data[7:0], 8'h3C);
    check("mcu_no_sd", dl.prog_we, 0);
    step(1, 0, 0, 0, 0);
    check("mcu_one_shot", dl.prom_we, 0);
    step(1, 0, 0, 0, 0);
    step(1, 1, 'hA0800, 8'h77, 0);
    repeat (4) step(1, 0, 0, 0, 0);

    // Back-to-back bytes against a slow ack: the third is dropped
    step(1, 1, 'h100, 8'hB1, 0);
    step(1, 0, 0, 0, 0);
    step(1, 1, 'h102, 8'hB2, 0);
    step(1, 0, 0, 0, 0);
    step(1, 1, 'h104, 8'hB3, 0);
    check("b2b_ovf", dl.ovf, 1);
    repeat (15) step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    check("b2b_second", dl.prog_addr, 22'h81);
    step(1, 0, 0, 0, 1);
    repeat (6) step(1, 0, 0, 0, 0);

    // Window closes while a write waits for its ack
    step(1, 1, 'h20000, 8'hC7, 0);
    step(0, 0, 0, 0, 0);
    repeat (4) step(0, 0, 0, 0, 0);
    check("drain_busy_wait", dl.dwnld_busy, 1);
    step(0, 0, 0, 0, 1);
    check("drain_busy_gap", dl.dwnld_busy, 1);
    step(0, 0, 0, 0, 0);
    check("drain_busy_done", dl.dwnld_busy, 0);
    step(0, 0, 0, 0, 0);

    // Asynchronous reset while a write is outstanding and a byte is buffered
    step(1, 1, 'h40010, 8'hD1, 0);
    step(1, 0, 0, 0, 0);
    step(1, 1, 'h40012, 8'hD2, 0);
    dl.downloading = 1'b0;
    dl.ioctl_wr    = 1'b0;
    rst            = 1'b1;
    #1;
    check("rst_mid_we", dl.prog_we, 0);
    check("rst_mid_busy", dl.dwnld_busy, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
    model_reset();
    check("rst_mid_ovf", dl.ovf, 0);
    repeat (4) step(0, 0, 0, 0, 0);

    // Random byte streams with random ack latency and stray acks
    begin
      int ack_wait = 0;
      bit prev_wait = 0;
      for (int i = 0; i < 2000; i++) begin
        bit ack, dlw, wr;
        int a;
        if (m_wait && !prev_wait) ack_wait = int'($urandom_range(0, 6));
        prev_wait = m_wait;
        ack = 1'b0;
        if (m_wait) begin
          if (ack_wait == 0) ack = 1'b1;
          else ack_wait--;
        end else begin
          ack = ($urandom_range(0, 7) == 0);
        end
        dlw = ($urandom_range(0, 15) != 0);
        wr  = ($urandom_range(0, 2) == 0);
        if ($urandom_range(0, 3) == 0)
          a = edges[$urandom_range(0, 6)] + int'($urandom_range(0, 3)) - 2;
        else
          a = int'($urandom_range(0, ENDA + 'h40));
        step(dlw, wr, a, 8'($urandom), ack);
      end
      for (int i = 0; i < 40; i++) step(0, 0, 0, 0, m_wait);
    end
    check("final_busy", dl.dwnld_busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
